// File: rtl/mem_pkg.sv
// Shared encodings for the CPU data-memory port: access direction, access size
// and the responder state machine.
package mem_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core (master) and the data-memory
// responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        mem_rw;
    logic [31:0] mem_aout;
    logic [31:0] mem_dout;
    logic [1:0]  store_sel;
    logic [31:0] mem_din;
    logic        resp_valid;
    logic        resp_err;

    modport master (
        output req_valid, mem_rw, mem_aout, mem_dout, store_sel,
        input  req_ready, mem_din, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, mem_rw, mem_aout, mem_dout, store_sel,
        output req_ready, mem_din, resp_valid, resp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Turns a byte address offset and access size into byte strobes and
// lane-replicated store data; flags misaligned or reserved-size accesses.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  store_sel_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  strobe_o,
    output logic [31:0] wdata_rep_o,
    output logic        align_err_o
);

    always_comb begin
        strobe_o    = 4'b0000;
        wdata_rep_o = wdata_i;
        align_err_o = 1'b0;
        case (store_sel_i)
            SEL_BYTE: begin
                strobe_o    = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            SEL_HALF: begin
                wdata_rep_o = {2{wdata_i[15:0]}};
                if (addr_lo_i[0]) begin
                    align_err_o = 1'b1;
                end else begin
                    strobe_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                end
            end
            SEL_WORD: begin
                if (addr_lo_i != 2'b00) begin
                    align_err_o = 1'b1;
                end else begin
                    strobe_o = 4'b1111;
                end
            end
            default: align_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request capture, programmable wait states,
// one-cycle response pulse, and a word RAM with byte-strobed stores.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    data_mem_responder_if.slave bus
);

    localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rw_q;
    logic [31:0]   addr_q, wdata_q;
    logic [1:0]    sel_q;
    logic [31:0]   din_q, din_d;
    logic          rv_q, rv_d, rerr_q, rerr_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          accept, commit;
    logic          cur_rw;
    logic [31:0]   cur_addr, cur_wdata;
    logic [1:0]    cur_sel;
    logic [AW-1:0] widx;
    logic [3:0]    strobe;
    logic [31:0]   wdata_rep;
    logic          align_err, range_err, req_err;

    assign accept = bus.req_valid && (state_q == IDLE);

    // With zero wait states the commit edge is the acceptance edge, so the
    // live bus is used while idle and the captured copy afterwards.
    assign cur_rw    = (state_q == IDLE) ? bus.mem_rw    : rw_q;
    assign cur_addr  = (state_q == IDLE) ? bus.mem_aout  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? bus.mem_dout  : wdata_q;
    assign cur_sel   = (state_q == IDLE) ? bus.store_sel : sel_q;

    assign widx      = cur_addr[AW+1:2];
    assign range_err = {2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign req_err   = align_err | range_err;

    mem_lane_align u_align (
        .addr_lo_i   (cur_addr[1:0]),
        .store_sel_i (cur_sel),
        .wdata_i     (cur_wdata),
        .strobe_o    (strobe),
        .wdata_rep_o (wdata_rep),
        .align_err_o (align_err)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= MEM_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= SEL_BYTE;
            din_q   <= '0;
            rv_q    <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            rv_q    <= rv_d;
            rerr_q  <= rerr_d;
            if (accept) begin
                rw_q    <= bus.mem_rw;
                addr_q  <= bus.mem_aout;
                wdata_q <= bus.mem_dout;
                sel_q   <= bus.store_sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = BUSY;
                        cnt_d   = CW'(LOAD);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gating with reset keeps a zero-wait request from writing while reset is held.
    assign commit = reset && (state_d == RESP) && (state_q != RESP);

    always_comb begin
        din_d  = din_q;
        rv_d   = (state_q == RESP);
        rerr_d = (state_q == RESP) && req_err;
        if (commit) begin
            if (req_err) begin
                din_d = '0;
            end else if (cur_rw == MEM_READ) begin
                din_d = mem_q[widx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (commit && (cur_rw == MEM_WRITE) && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem_q[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_din    = din_q;
    assign bus.resp_valid = rv_q;
    assign bus.resp_err   = rerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one DUT with two wait states and one
// with none, driven from the core side and checked against hand-derived values.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus2();
    data_mem_responder_if bus0();

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus2.slave)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus0.slave)
    );

    task automatic drive(input bit w0, input logic v, input logic rw,
                         input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        if (w0) begin
            bus0.req_valid = v; bus0.mem_rw = rw; bus0.mem_aout = a;
            bus0.mem_dout = d;  bus0.store_sel = s;
        end else begin
            bus2.req_valid = v; bus2.mem_rw = rw; bus2.mem_aout = a;
            bus2.mem_dout = d;  bus2.store_sel = s;
        end
    endtask

    // Called at a negedge with the responder idle; returns at the negedge after
    // acceptance with the bus scrambled, so captured values are what matter.
    task automatic issue(input bit w0, input logic rw, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s);
        drive(w0, 1'b1, rw, a, d, s);
        @(posedge clk);
        @(negedge clk);
        drive(w0, 1'b0, ~rw, 32'hFFFF_FFFC, 32'h0BAD_0BAD, SEL_RSVD);
    endtask

    // cyc counts negedges since acceptance; 20 means the response never came.
    task automatic wait_resp(input bit w0, output int cyc, output logic err, output logic [31:0] din);
        cyc = 1;
        while (((w0 ? bus0.resp_valid : bus2.resp_valid) !== 1'b1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        err = w0 ? bus0.resp_err : bus2.resp_err;
        din = w0 ? bus0.mem_din : bus2.mem_din;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, MEM_READ, 32'h0, 32'h0, SEL_WORD);
        drive(1'b1, 1'b0, MEM_READ, 32'h0, 32'h0, SEL_WORD);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus2.req_ready !== 1'b1 || bus2.resp_valid !== 1'b0 || bus2.resp_err !== 1'b0 || bus2.mem_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rv=%b err=%b din=%h expected 1 0 0 00000000",
                     bus2.req_ready, bus2.resp_valid, bus2.resp_err, bus2.mem_din);
        end
        checks++;
        if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0 || bus0.mem_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_state_w0: ready=%b rv=%b din=%h expected 1 0 00000000",
                     bus0.req_ready, bus0.resp_valid, bus0.mem_din);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int cyc; logic e; logic [31:0] d;
        issue(1'b0, MEM_WRITE, 32'h10, 32'hDEADBEEF, SEL_WORD);
        checks++;
        if (bus2.req_ready !== 1'b0) begin
            errors++; $display("FAIL busy_ready: got %b expected 0", bus2.req_ready);
        end
        checks++;
        if (bus2.resp_valid !== 1'b0) begin
            errors++; $display("FAIL early_resp: got %b expected 0", bus2.resp_valid);
        end
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (cyc !== 4 || e !== 1'b0) begin
            errors++; $display("FAIL wr_latency: cyc=%0d err=%b expected cyc=4 err=0", cyc, e);
        end
        checks++;
        if (bus2.req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after: got %b expected 1", bus2.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus2.resp_valid !== 1'b0) begin
            errors++; $display("FAIL resp_pulse_width: got %b expected 0", bus2.resp_valid);
        end
        issue(1'b0, MEM_READ, 32'h10, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (cyc !== 4 || e !== 1'b0 || d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_10: cyc=%0d err=%b din=%h expected 4 0 deadbeef", cyc, e, d);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus2.mem_din !== 32'hDEADBEEF) begin
            errors++; $display("FAIL din_hold: got %h expected deadbeef", bus2.mem_din);
        end
    endtask

    task automatic test_strobes();
        int cyc; logic e; logic [31:0] d;
        issue(1'b0, MEM_WRITE, 32'h13, 32'h0000_00AA, SEL_BYTE);
        wait_resp(1'b0, cyc, e, d);
        issue(1'b0, MEM_READ, 32'h10, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hAAADBEEF) begin
            errors++; $display("FAIL byte_store: err=%b din=%h expected 0 aaadbeef", e, d);
        end
        issue(1'b0, MEM_WRITE, 32'h10, 32'h0000_1234, SEL_HALF);
        wait_resp(1'b0, cyc, e, d);
        issue(1'b0, MEM_READ, 32'h10, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hAAAD1234) begin
            errors++; $display("FAIL half_store: err=%b din=%h expected 0 aaad1234", e, d);
        end
        issue(1'b0, MEM_READ, 32'h13, 32'h0, SEL_BYTE);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hAAAD1234) begin
            errors++; $display("FAIL byte_read_full_word: err=%b din=%h expected 0 aaad1234", e, d);
        end
    endtask

    task automatic test_errors();
        int cyc; logic e; logic [31:0] d;
        issue(1'b0, MEM_WRITE, 32'h11, 32'h0000_5678, SEL_HALF);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (cyc !== 4 || e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL half_misalign: cyc=%0d err=%b din=%h expected 4 1 00000000", cyc, e, d);
        end
        issue(1'b0, MEM_READ, 32'h10, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hAAAD1234) begin
            errors++; $display("FAIL misalign_no_write: err=%b din=%h expected 0 aaad1234", e, d);
        end
        issue(1'b0, MEM_WRITE, 32'h10, 32'hFFFF_FFFF, SEL_RSVD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL rsvd_sel: err=%b din=%h expected 1 00000000", e, d);
        end
        issue(1'b0, MEM_READ, 32'h12, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL word_misalign_rd: err=%b din=%h expected 1 00000000", e, d);
        end
        issue(1'b0, MEM_READ, 32'h10, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hAAAD1234) begin
            errors++; $display("FAIL rsvd_no_write: err=%b din=%h expected 0 aaad1234", e, d);
        end
    endtask

    task automatic test_range();
        int cyc; logic e; logic [31:0] d;
        issue(1'b0, MEM_WRITE, 32'h0, 32'h0000_0000, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        issue(1'b0, MEM_WRITE, 32'hFFC, 32'h0123_4567, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        issue(1'b0, MEM_READ, 32'hFFC, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'h0123_4567) begin
            errors++; $display("FAIL last_word: err=%b din=%h expected 0 01234567", e, d);
        end
        issue(1'b0, MEM_READ, 32'h1000, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL range_rd: err=%b din=%h expected 1 00000000", e, d);
        end
        issue(1'b0, MEM_WRITE, 32'h1000, 32'h9999_9999, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL range_wr: err=%b expected 1", e);
        end
        issue(1'b0, MEM_READ, 32'h0, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL range_no_alias: err=%b din=%h expected 0 00000000", e, d);
        end
    endtask

    task automatic test_reset_abort();
        int cyc; int seen; logic e; logic [31:0] d;
        issue(1'b0, MEM_WRITE, 32'h20, 32'h1111_1111, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        issue(1'b0, MEM_WRITE, 32'h20, 32'h5555_5555, SEL_WORD);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus2.req_ready !== 1'b1 || bus2.resp_valid !== 1'b0 || bus2.mem_din !== 32'h0) begin
            errors++;
            $display("FAIL abort_state: ready=%b rv=%b din=%h expected 1 0 00000000",
                     bus2.req_ready, bus2.resp_valid, bus2.mem_din);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus2.resp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL abort_no_resp: got %0d pulses expected 0", seen);
        end
        issue(1'b0, MEM_READ, 32'h20, 32'h0, SEL_WORD);
        wait_resp(1'b0, cyc, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'h1111_1111) begin
            errors++; $display("FAIL abort_no_write: err=%b din=%h expected 0 11111111", e, d);
        end
    endtask

    task automatic test_zero_wait();
        int cyc; logic e; logic [31:0] d;
        issue(1'b1, MEM_WRITE, 32'h30, 32'hCAFE_F00D, SEL_WORD);
        checks++;
        if (bus0.req_ready !== 1'b0 || bus0.resp_valid !== 1'b0) begin
            errors++; $display("FAIL w0_resp_state: ready=%b rv=%b expected 0 0", bus0.req_ready, bus0.resp_valid);
        end
        wait_resp(1'b1, cyc, e, d);
        checks++;
        if (cyc !== 2 || e !== 1'b0) begin
            errors++; $display("FAIL w0_latency: cyc=%0d err=%b expected cyc=2 err=0", cyc, e);
        end
        issue(1'b1, MEM_READ, 32'h30, 32'h0, SEL_WORD);
        wait_resp(1'b1, cyc, e, d);
        checks++;
        if (cyc !== 2 || d !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL w0_raw: cyc=%0d din=%h expected 2 cafef00d", cyc, d);
        end
        issue(1'b1, MEM_WRITE, 32'h31, 32'h0000_005A, SEL_BYTE);
        wait_resp(1'b1, cyc, e, d);
        issue(1'b1, MEM_READ, 32'h30, 32'h0, SEL_WORD);
        wait_resp(1'b1, cyc, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hCAFE_5A0D) begin
            errors++; $display("FAIL w0_byte_lane1: err=%b din=%h expected 0 cafe5a0d", e, d);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_errors();
        test_range();
        test_reset_abort();
        test_zero_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
